hist_readout: RTL and testbench

Reader side of the 16-bin histogram accumulator.
- On a read request, it snapshots all bins in one cycle and optionally pulses the accumulator's resethist input to clear it.
- It then streams the snapshot out as bytes over a valid/ready byte interface, which feeds the board's serial/USB transmitter.
- It owns the accumulator's clear control, so readout and clear stay coherent.

---
 rtl/hist_pkg.sv | 18 +
 rtl/hist_readout.sv | 129 ++++++++++++
 tb/tb_hist_readout.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/hist_pkg.sv
// Shared types and defaults for the histogram readout path.
// Bin k of a flattened histogram sits at [k*BINW +: BINW].
package hist_pkg;

    localparam int NBINS_DEF     = 16;
    localparam int BINW_DEF      = 32;
    localparam int BYTES_PER_BIN = BINW_DEF / 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int frame_bytes(input int nbins, input int binw);
        return nbins * (binw / 8);
    endfunction

endpackage

// File: rtl/hist_readout.sv
// Snapshots the histogram, optionally clears the accumulator, and
// streams the snapshot out LSB-first as bytes over valid/ready.
module hist_readout
    import hist_pkg::*;
#(
    parameter int NBINS       = NBINS_DEF,
    parameter int BINW        = BINW_DEF,
    parameter int CLEAR_AFTER = 1
) (
    input  logic                  clkin,
    input  logic                  rstn,
    input  logic [NBINS*BINW-1:0] histo_flat,
    input  logic                  readreq,
    output logic                  resethist,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int NBYTES = frame_bytes(NBINS, BINW);
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NBINS*BINW-1:0]   r_snap;
    logic [NBINS*BINW-1:0]   w_snap_nxt;
    logic [IDXW-1:0]         r_idx;
    logic [IDXW-1:0]         w_idx_nxt;
    logic [IDXW-1:0]         w_idx_inc;
    logic [7:0]              r_tx_data;
    logic [7:0]              w_data_nxt;
    logic                    r_tx_valid;
    logic                    w_valid_nxt;
    logic                    r_busy;
    logic                    w_busy_nxt;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    r_resethist;
    logic                    w_rh_nxt;
    logic                    w_xfer;
    logic                    w_last;

    assign w_xfer    = r_tx_valid && tx_ready;
    assign w_last    = (r_idx == LAST);
    assign w_idx_inc = r_idx + 1'b1;

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (readreq) w_state_nxt = SEND;
            SEND: if (w_xfer && w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of every registered output; pulses default low.
    always_comb begin
        w_snap_nxt  = r_snap;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_tx_data;
        w_valid_nxt = r_tx_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_rh_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (readreq) begin
                    w_snap_nxt  = histo_flat;
                    w_idx_nxt   = '0;
                    w_data_nxt  = histo_flat[7:0];
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_rh_nxt    = (CLEAR_AFTER != 0);
                end
            end
            SEND: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt  = w_idx_inc;
                        w_data_nxt = r_snap[{w_idx_inc, 3'b000} +: 8];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_snap      <= '0;
            r_idx       <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_resethist <= 1'b0;
        end else begin
            r_snap      <= w_snap_nxt;
            r_idx       <= w_idx_nxt;
            r_tx_data   <= w_data_nxt;
            r_tx_valid  <= w_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_resethist <= w_rh_nxt;
        end
    end

    assign resethist = r_resethist;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_hist_readout.sv
// Directed bench for hist_readout: table-driven frames plus
// reset-abort and continuous-readout sequences.
module tb_hist_readout;
    import hist_pkg::*;

    localparam int NB     = 16;
    localparam int BW     = 32;
    localparam int NBYTES = 64;

    logic             clkin = 1'b0;
    logic             rstn;
    logic [NB*BW-1:0] histo_flat;
    logic             readreq;
    logic             readreq0;
    logic             tx_ready;

    logic       resethist, tx_valid, busy, done;
    logic [7:0] tx_data;
    logic       resethist0, tx_valid0, busy0, done0;
    logic [7:0] tx_data0;

    always #5 clkin = ~clkin;

    hist_readout #(.NBINS(NB), .BINW(BW), .CLEAR_AFTER(1)) dut (
        .clkin(clkin), .rstn(rstn), .histo_flat(histo_flat),
        .readreq(readreq), .resethist(resethist), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    hist_readout #(.NBINS(NB), .BINW(BW), .CLEAR_AFTER(0)) dut0 (
        .clkin(clkin), .rstn(rstn), .histo_flat(histo_flat),
        .readreq(readreq0), .resethist(resethist0), .tx_data(tx_data0),
        .tx_valid(tx_valid0), .tx_ready(tx_ready), .busy(busy0), .done(done0)
    );

    typedef struct {
        logic       req;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       eb;
        logic       edn;
        logic       erh;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [7:0] mbyte(input logic [NB*BW-1:0] s, input int j);
        logic [31:0] b;
        b = s[(j / 4) * 32 +: 32];
        b = b >> ((j % 4) * 8);
        return b[7:0];
    endfunction

    function automatic logic pat(input int mode, input int c);
        if (mode == 0) return 1'b1;
        return ((c % 4) == 0) || ((c % 4) == 3);
    endfunction

    // Expected cycle-by-cycle outputs of one frame, seen #1 after each edge.
    task automatic build(input int mode, input int req_at, input logic [NB*BW-1:0] s);
        vec_t v;
        int   k;
        int   c;
        vecs.delete();
        v.req = 1'b1; v.rdy = pat(mode, 0); v.ev = 1'b1; v.ed = mbyte(s, 0);
        v.eb = 1'b1; v.edn = 1'b0; v.erh = 1'b1;
        vecs.push_back(v);
        k = 0;
        c = 1;
        while (k < NBYTES) begin
            v.req = (c == req_at);
            v.rdy = pat(mode, c);
            if (v.rdy) k++;
            v.ev  = (k < NBYTES);
            v.ed  = (k < NBYTES) ? mbyte(s, k) : 8'h00;
            v.eb  = (k < NBYTES);
            v.edn = (k == NBYTES);
            v.erh = 1'b0;
            vecs.push_back(v);
            c++;
        end
        v.req = 1'b0; v.rdy = 1'b1; v.ev = 1'b0; v.ed = 8'h00;
        v.eb = 1'b0; v.edn = 1'b0; v.erh = 1'b0;
        vecs.push_back(v);
        vecs.push_back(v);
    endtask

    task automatic apply(input string name, input bit scramble, input int nmax);
        vec_t v;
        logic ok;
        for (int i = 0; i < vecs.size() && i < nmax; i++) begin
            v = vecs[i];
            readreq  = v.req;
            tx_ready = v.rdy;
            @(posedge clkin);
            #1;
            if (scramble) histo_flat = {16{$urandom}};
            n_chk++;
            ok = (tx_valid == v.ev) && (busy == v.eb) && (done == v.edn) &&
                 (resethist == v.erh) && (!v.ev || tx_data == v.ed);
            if (!ok) begin
                n_fail++;
                $display("FAIL %s vec %0d: got v=%b d=%h b=%b dn=%b rh=%b, want v=%b d=%h b=%b dn=%b rh=%b",
                         name, i, tx_valid, tx_data, busy, done, resethist,
                         v.ev, v.ed, v.eb, v.edn, v.erh);
            end
        end
        readreq = 1'b0;
    endtask

    task automatic check_zero(input string name);
        n_chk++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 ||
            done !== 1'b0 || resethist !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got v=%b d=%h b=%b dn=%b rh=%b, want all zero",
                     name, tx_valid, tx_data, busy, done, resethist);
        end
    endtask

    logic [NB*BW-1:0] s1, s2;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int j, frames, gap, cyc;
        rstn = 1'b0; readreq = 1'b0; readreq0 = 1'b0; tx_ready = 1'b0;
        for (int k = 0; k < NB; k++) s1[k*32 +: 32] = 32'h01020300 + k;
        for (int k = 0; k < NB; k++) s2[k*32 +: 32] = 32'hA0B0C000 + 32'(k * 17);
        histo_flat = s1;
        repeat (2) @(posedge clkin);
        #1;
        check_zero("reset");
        n_chk++;
        if (tx_valid0 || busy0 || done0 || resethist0 || tx_data0 != 8'h00) begin
            n_fail++;
            $display("FAIL reset0: got v=%b d=%h b=%b dn=%b rh=%b, want all zero",
                     tx_valid0, tx_data0, busy0, done0, resethist0);
        end
        #2 rstn = 1'b1;

        // Hand check of the first bytes of the basic pattern
        n_chk++;
        if (mbyte(s1, 0) != 8'h00 || mbyte(s1, 1) != 8'h03 ||
            mbyte(s1, 4) != 8'h01 || mbyte(s1, 7) != 8'h01) begin
            n_fail++;
            $display("FAIL pattern: got %h %h %h %h, want 00 03 01 01",
                     mbyte(s1, 0), mbyte(s1, 1), mbyte(s1, 4), mbyte(s1, 7));
        end

        build(0, -1, s1);
        apply("basic", 1'b0, 1000);

        build(1, -1, s1);
        apply("backpressure", 1'b0, 1000);

        histo_flat = s2;
        build(0, -1, s2);
        apply("coherence", 1'b1, 1000);
        histo_flat = s1;

        build(0, 10, s1);
        apply("ignored_req", 1'b0, 1000);

        build(0, -1, s1);
        apply("pre_reset", 1'b0, 21);
        #2 rstn = 1'b0;
        #1;
        check_zero("reset_async");
        @(posedge clkin);
        #1;
        check_zero("reset_held");
        #2 rstn = 1'b1;
        histo_flat = s2;
        build(0, -1, s2);
        apply("after_reset", 1'b0, 1000);

        histo_flat = s1;
        tx_ready = 1'b1;
        readreq0 = 1'b1;
        j = 0; frames = 0; gap = 0; cyc = 0;
        while (cyc < 400 && frames < 3) begin
            @(posedge clkin);
            #1;
            cyc++;
            n_chk++;
            if (resethist0) begin
                n_fail++;
                $display("FAIL clear0_rh: got resethist=1, want 0 (cycle %0d)", cyc);
            end
            if (tx_valid0) begin
                if (frames > 0 && j == 0) begin
                    n_chk++;
                    if (gap != 1) begin
                        n_fail++;
                        $display("FAIL clear0_gap: got %0d idle cycles, want 1", gap);
                    end
                end
                gap = 0;
                n_chk++;
                if (tx_data0 != mbyte(s1, j)) begin
                    n_fail++;
                    $display("FAIL clear0_byte %0d: got %h, want %h", j, tx_data0, mbyte(s1, j));
                end
                j++;
                if (j == NBYTES) begin
                    j = 0;
                    frames++;
                end
            end else begin
                gap++;
            end
        end
        readreq0 = 1'b0;
        n_chk++;
        if (frames != 3) begin
            n_fail++;
            $display("FAIL clear0_frames: got %0d frames, want 3", frames);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
